// File: rtl/controlador_rodada.sv
// Round controller for a social-deduction game: sequences night, day,
// voting and result phases on a tick time base, counts rounds and
// reports the remaining time of the current phase.
module controlador_rodada #(
  parameter int T_NOITE = 30,
  parameter int T_DIA   = 60,
  parameter int T_VOTO  = 20,
  parameter int T_RES   = 5,
  parameter int N       = 7,
  parameter int NR      = 4
) (
  input  logic          clock,
  input  logic          zera_n,
  input  logic          iniciar,
  input  logic          tick,
  input  logic          pausa,
  input  logic          pronto,
  input  logic          encerra,
  output logic [2:0]    fase,
  output logic [N-1:0]  restante,
  output logic [NR-1:0] rodada,
  output logic          troca_fase,
  output logic          ativo
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    NOITE     = 3'd1,
    DIA       = 3'd2,
    VOTACAO   = 3'd3,
    RESULTADO = 3'd4,
    FIM       = 3'd5
  } estado_t;

  // Timer load values: the timer counts down to zero, so a phase of
  // T ticks starts at T-1 and times out on the tick seen at zero.
  localparam logic [N-1:0]  CARGA_NOITE = N'(T_NOITE - 1);
  localparam logic [N-1:0]  CARGA_DIA   = N'(T_DIA - 1);
  localparam logic [N-1:0]  CARGA_VOTO  = N'(T_VOTO - 1);
  localparam logic [N-1:0]  CARGA_RES   = N'(T_RES - 1);
  localparam logic [N-1:0]  UM_N        = N'(1);
  localparam logic [NR-1:0] UM_NR       = NR'(1);
  localparam logic [NR-1:0] RODADA_MAX  = {NR{1'b1}};

  estado_t       estado_q, estado_d;
  logic [N-1:0]  restante_q, restante_d;
  logic [NR-1:0] rodada_q, rodada_d;
  logic          troca_q, troca_d;
  logic          ativo_q, ativo_d;

  logic avanca;
  logic timeout;
  logic antecipa;

  // Qualified time-base events; pausa freezes both the timer and pronto.
  always_comb begin
    avanca   = tick & ~pausa;
    timeout  = avanca & (restante_q == '0);
    antecipa = pronto & ~pausa;
  end

  // Next-state, timer and round logic; every output is computed here and
  // registered below so all outputs change together on the clock edge.
  always_comb begin
    estado_d   = estado_q;
    restante_d = restante_q;
    rodada_d   = rodada_q;
    troca_d    = 1'b0;

    unique case (estado_q)
      OCIOSO, FIM: begin
        restante_d = '0;
        if (iniciar) begin
          estado_d   = NOITE;
          restante_d = CARGA_NOITE;
          rodada_d   = UM_NR;
          troca_d    = 1'b1;
        end
      end

      NOITE, DIA, VOTACAO: begin
        if (encerra) begin
          // Game over wins over everything, even while paused.
          estado_d   = FIM;
          restante_d = '0;
          troca_d    = 1'b1;
        end else if (timeout || antecipa) begin
          // Timeout and pronto together still yield a single advance.
          troca_d = 1'b1;
          if (estado_q == NOITE) begin
            estado_d   = DIA;
            restante_d = CARGA_DIA;
          end else if (estado_q == DIA) begin
            estado_d   = VOTACAO;
            restante_d = CARGA_VOTO;
          end else begin
            estado_d   = RESULTADO;
            restante_d = CARGA_RES;
          end
        end else if (avanca) begin
          restante_d = restante_q - UM_N;
        end
      end

      RESULTADO: begin
        // The result display always runs its full length; pronto is ignored.
        if (timeout) begin
          troca_d = 1'b1;
          if (encerra) begin
            estado_d   = FIM;
            restante_d = '0;
          end else begin
            estado_d   = NOITE;
            restante_d = CARGA_NOITE;
            if (rodada_q != RODADA_MAX) begin
              rodada_d = rodada_q + UM_NR;
            end
          end
        end else if (avanca) begin
          restante_d = restante_q - UM_N;
        end
      end

      default: begin
        // Unused codes recover to idle on the next clock.
        estado_d   = OCIOSO;
        restante_d = '0;
        troca_d    = 1'b1;
      end
    endcase

    ativo_d = (estado_d == NOITE) || (estado_d == DIA) ||
              (estado_d == VOTACAO) || (estado_d == RESULTADO);
  end

  // State and output registers; zera_n clears everything at once, dropping
  // any progress through the current phase.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      estado_q   <= OCIOSO;
      restante_q <= '0;
      rodada_q   <= '0;
      troca_q    <= 1'b0;
      ativo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      restante_q <= restante_d;
      rodada_q   <= rodada_d;
      troca_q    <= troca_d;
      ativo_q    <= ativo_d;
    end
  end

  assign fase       = estado_q;
  assign restante   = restante_q;
  assign rodada     = rodada_q;
  assign troca_fase = troca_q;
  assign ativo      = ativo_q;

endmodule

// File: doc/controlador_rodada.md
CONTROLADOR_RODADA -- requirements
Module: controlador_rodada

Interface
REQ-001 The block SHALL have parameter T_NOITE, default 30, meaning the night phase length in ticks.
REQ-002 The block SHALL have parameter T_DIA, default 60, meaning the day/discussion phase length in ticks.
REQ-003 The block SHALL have parameter T_VOTO, default 20, meaning the voting phase length in ticks.
REQ-004 The block SHALL have parameter T_RES, default 5, meaning the result display length in ticks.
REQ-005 The block SHALL have parameter N, default 7, meaning the timer width; all T_* values SHALL lie in 1..2^N-1.
REQ-006 The block SHALL have parameter NR, default 4, meaning the round counter width.
REQ-007 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-008 The block SHALL have these ports:
  clock  in  1  system clock, rising edge
  zera_n  in  1  asynchronous active-low reset
  iniciar  in  1  start game (level, sampled each clock)
  tick  in  1  one-cycle time-base pulse
  pausa  in  1  freezes timer and pronto while high
  pronto  in  1  all players acted; ends current phase early
  encerra  in  1  game-over condition from the rules logic
  fase  out  3  current state code
  restante  out  N  ticks remaining in the current phase
  rodada  out  NR  current round number
  troca_fase  out  1  one-cycle pulse on entry to any new state
  ativo  out  1  high in NOITE, DIA, VOTACAO, RESULTADO

Function
REQ-009 State codes SHALL be OCIOSO=0, NOITE=1, DIA=2, VOTACAO=3, RESULTADO=4, FIM=5; codes 6-7 SHALL return to OCIOSO on the next clock.
REQ-010 All outputs SHALL be registered, and all transitions SHALL take effect on the clock edge at which their condition is sampled.
REQ-011 On every state entry, restante SHALL load T_<phase>-1; in OCIOSO and FIM it SHALL hold 0.
REQ-012 In an active phase, tick=1 with pausa=0 and restante>0 SHALL decrement restante by 1.
REQ-013 The timeout condition SHALL be tick=1, pausa=0 and restante=0.
REQ-014 Early end (pronto=1, pausa=0) SHALL apply in NOITE, DIA and VOTACAO only, and SHALL be ignored in RESULTADO.
REQ-015 Phase end (timeout or early end) SHALL advance NOITE->DIA->VOTACAO->RESULTADO.
REQ-016 When RESULTADO ends on timeout, the block SHALL enter FIM if encerra=1; otherwise it SHALL enter NOITE and increment rodada, saturating at 2^NR-1.
REQ-017 encerra=1 in NOITE, DIA or VOTACAO SHALL enter FIM on the next clock, regardless of pausa, and with priority over the timeout and pronto conditions.
REQ-018 iniciar=1 in OCIOSO or FIM SHALL enter NOITE with rodada=1; iniciar SHALL be ignored in active phases.
REQ-019 Simultaneous timeout and pronto SHALL produce exactly one phase advance.
REQ-020 troca_fase SHALL be 1 exactly in the first cycle of each new state, including entry to FIM; it SHALL be 0 for a self-loop or a held state.
REQ-021 ativo SHALL be a registered decode of fase.

Reset
REQ-022 zera_n=0 SHALL immediately force fase=0, restante=0, rodada=0, troca_fase=0 and ativo=0, independent of clock.
REQ-023 After zera_n deasserts, the block SHALL remain in OCIOSO until iniciar is sampled high.
REQ-024 Reset asserted mid-phase SHALL discard all phase progress.

Verification (T_NOITE=3, T_DIA=4, T_VOTO=2, T_RES=2, N=4, NR=2)
REQ-025 Scenario: iniciar pulse then 3 ticks -> fase 1 with restante 2,1,0, then fase=2, restante=3, troca_fase pulsed on both entries.
REQ-026 Scenario: pronto in DIA with restante=3 -> next clock fase=3, restante=1; pronto in RESULTADO -> no change.
REQ-027 Scenario: pausa=1 with ticks and pronto in NOITE -> restante and fase frozen; encerra=1 under pausa -> fase=5 next clock.
REQ-028 Scenario: four full rounds with encerra=0 -> rodada reads 1,2,3,3 (saturates at 3).
REQ-029 Scenario: tick and pronto in the same cycle in VOTACAO at restante=0 -> single advance to fase=4, restante=1.
REQ-030 Scenario: zera_n pulsed low between clock edges during DIA -> outputs 0 immediately; iniciar then yields fase=1, rodada=1.
